// File: rtl/output_buffer_pkg.sv
// Shared configuration for the systolic array receive path: tile geometry,
// partial-sum row type and the output buffer state encoding.
package output_buffer_pkg;

  localparam int A_rows     = 4;
  localparam int sys_cols   = 4;
  localparam int P_BITWIDTH = 32;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] psum_row_t;

  typedef enum logic [1:0] {
    OB_IDLE,
    OB_CAPTURE,
    OB_DRAIN
  } ob_state_t;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_buffer_skew_delay.sv
// Valid delay line: taps[k] is in_valid delayed by k cycles (taps[0] is
// undelayed), giving one write enable per skewed array column.
module skew_delay #(
  parameter int DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  output logic [DEPTH:0] taps
);

  generate
    if (DEPTH == 0) begin : g_none
      assign taps = in_valid;
    end else begin : g_line
      logic [DEPTH-1:0] stages;

      always_ff @(posedge clk) begin
        if (!rst || clr) begin
          stages <= '0;
        end else begin
          stages[0] <= in_valid;
          for (int k = 1; k < DEPTH; k++) begin
            stages[k] <= stages[k-1];
          end
        end
      end

      assign taps = {stages, in_valid};
    end
  endgenerate

endmodule

// File: rtl/output_buffer.sv
// Receive end of the systolic array: deskews the column-staggered partial sums
// into a row-indexed tile, then drains one full row per valid/ready beat.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int ROWS = A_rows,
  parameter int COLS = sys_cols,
  parameter int PW   = P_BITWIDTH,
  parameter int RELU = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     i_valid,
  input  logic [COLS-1:0][PW-1:0]  of_data,
  output logic                     i_ready,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [COLS-1:0][PW-1:0]  o_data,
  output logic                     o_last,
  output logic                     o_done,
  output logic                     o_overrun
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int RW = idx_width(ROWS);

  ob_state_t state, state_next;

  logic [CW-1:0]            wr_row [COLS];
  logic [CW-1:0]            rd_ptr;
  logic [COLS-1:0][PW-1:0]  mem [ROWS];
  logic [COLS-1:0][PW-1:0]  cap_row;
  logic [COLS-1:0]          col_en;
  logic [COLS-1:0]          wen;
  logic                     accept;
  logic                     in_wen;
  logic                     overrun_evt;
  logic                     last_write;
  logic                     beat_xfer;
  logic                     last_beat;

  // Column 0 stops accepting once it has a full tile; later columns still
  // finish their skewed tails from the delay line.
  assign accept      = (state == OB_IDLE) ||
                       (state == OB_CAPTURE && wr_row[0] != CW'(ROWS));
  assign in_wen      = i_valid && accept;
  assign overrun_evt = i_valid && !accept;

  skew_delay #(
    .DEPTH (COLS - 1)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_wen),
    .taps     (col_en)
  );

  always_comb begin
    wen     = '0;
    cap_row = '0;
    for (int c = 0; c < COLS; c++) begin
      wen[c]     = col_en[c] && (wr_row[c] != CW'(ROWS));
      cap_row[c] = (RELU != 0 && of_data[c][PW-1]) ? '0 : of_data[c];
    end
  end

  assign last_write = wen[COLS-1] && (wr_row[COLS-1] == CW'(ROWS - 1));
  assign beat_xfer  = o_valid && o_ready;
  assign last_beat  = (rd_ptr == CW'(ROWS - 1));

  // Tile storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (wen[c]) begin
        mem[wr_row[c][RW-1:0]][c] <= cap_row[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state <= OB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      OB_IDLE: begin
        if (last_write) begin
          state_next = OB_DRAIN;
        end else if (in_wen) begin
          state_next = OB_CAPTURE;
        end
      end
      OB_CAPTURE: begin
        if (last_write) begin
          state_next = OB_DRAIN;
        end
      end
      OB_DRAIN: begin
        if (beat_xfer && last_beat) begin
          state_next = OB_IDLE;
        end
      end
      default: state_next = OB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      rd_ptr    <= '0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        wr_row[c] <= '0;
      end
    end else begin
      o_done <= beat_xfer && last_beat;
      if (overrun_evt) begin
        o_overrun <= 1'b1;
      end
      if (beat_xfer) begin
        rd_ptr <= last_beat ? '0 : rd_ptr + CW'(1);
      end
      for (int c = 0; c < COLS; c++) begin
        if (beat_xfer && last_beat) begin
          wr_row[c] <= '0;
        end else if (wen[c]) begin
          wr_row[c] <= wr_row[c] + CW'(1);
        end
      end
    end
  end

  // Read side is combinational from rd_ptr, so a stalled beat holds steady.
  assign i_ready = (state != OB_DRAIN);
  assign o_valid = (state == OB_DRAIN);
  assign o_data  = o_valid ? mem[rd_ptr[RW-1:0]] : '0;
  assign o_last  = o_valid && last_beat;

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: a RELU=0 and a RELU=1 instance share
// stimulus; expected rows come from the tile matrix, checked by a monitor.
module tb_output_buffer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int PW   = 32;

  typedef logic [COLS-1:0][PW-1:0] row_t;
  typedef struct packed {
    row_t data;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, iValid, oReady;
  row_t ofData;
  logic iReady [2];
  logic oValid [2];
  logic oLast [2];
  logic oDone [2];
  logic oOverrun [2];
  row_t oData [2];

  int total = 0;
  int bad = 0;
  beat_t expQ0[$];
  beat_t expQ1[$];
  logic [PW-1:0] vals [ROWS][COLS];
  int readyMode = 0;
  int pIdx = 0;
  logic doneDue [2] = '{1'b0, 1'b0};
  logic prevStall [2] = '{1'b0, 1'b0};
  logic prevLast [2];
  row_t prevData [2];

  output_buffer #(.ROWS(ROWS), .COLS(COLS), .PW(PW), .RELU(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .i_valid(iValid), .of_data(ofData),
    .i_ready(iReady[0]), .o_valid(oValid[0]), .o_ready(oReady), .o_data(oData[0]),
    .o_last(oLast[0]), .o_done(oDone[0]), .o_overrun(oOverrun[0])
  );

  output_buffer #(.ROWS(ROWS), .COLS(COLS), .PW(PW), .RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .i_valid(iValid), .of_data(ofData),
    .i_ready(iReady[1]), .o_valid(oValid[1]), .o_ready(oReady), .o_data(oData[1]),
    .o_last(oLast[1]), .o_done(oDone[1]), .o_overrun(oOverrun[1])
  );

  task automatic checkOutput(input string name, input logic [COLS*PW-1:0] actual,
                             input logic [COLS*PW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [PW-1:0] v, input int relu);
    return (relu != 0 && $signed(v) < 0) ? '0 : v;
  endfunction

  // The tile drains exactly as it was written, one matrix row per beat.
  task automatic pushTile();
    beat_t b;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < COLS; c++) b.data[c] = model(vals[r][c], k);
        b.last = (r == ROWS - 1);
        if (k == 0) expQ0.push_back(b);
        else expQ1.push_back(b);
      end
    end
  endtask

  // gapMode: 0 none, 1 fixed 1,1,0,0,1,1, 2 random. abortAt >= 0 pulls rst low.
  task automatic applyStimulus(input int gapMode, input int abortAt);
    int tIssue [ROWS];
    int gapPat [6] = '{1, 1, 0, 0, 1, 1};
    int t = 0;
    int r = 0;
    int tLast;
    bit v;
    while (r < ROWS) begin
      if (t == 0 || gapMode == 0) v = 1'b1;
      else if (gapMode == 1) v = (t < 6) ? (gapPat[t] != 0) : 1'b1;
      else v = ($urandom_range(0, 2) != 0);
      if (v) begin
        tIssue[r] = t;
        r++;
      end
      t++;
    end
    tLast = tIssue[ROWS-1] + COLS - 1;
    for (int tc = 0; tc <= tLast; tc++) begin
      iValid = 1'b0;
      for (int rr = 0; rr < ROWS; rr++) if (tIssue[rr] == tc) iValid = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        ofData[c] = $urandom;
        for (int rr = 0; rr < ROWS; rr++) if (tIssue[rr] + c == tc) ofData[c] = vals[rr][c];
      end
      if (tc == abortAt) rst = 1'b0;
      if (tc == tLast) pushTile();
      @(posedge clk);
      #1;
      if (tc == abortAt) begin
        rst = 1'b1;
        iValid = 1'b0;
        return;
      end
      for (int k = 0; k < 2; k++)
        checkOutput($sformatf("drainEntry%0d_t%0d", k, tc), oValid[k], tc == tLast);
    end
    iValid = 1'b0;
  endtask

  task automatic waitDrained();
    int n = 0;
    while ((expQ0.size() != 0 || expQ1.size() != 0 || oValid[0] || oValid[1]) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("[TB] FAIL drainTimeout: got %0d beats pending expected 0", expQ0.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag, input logic ovr);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_valid%0d", tag, k), oValid[k], 1'b0);
      checkOutput($sformatf("%s_data%0d", tag, k), oData[k], '0);
      checkOutput($sformatf("%s_last%0d", tag, k), oLast[k], 1'b0);
      checkOutput($sformatf("%s_done%0d", tag, k), oDone[k], 1'b0);
      checkOutput($sformatf("%s_overrun%0d", tag, k), oOverrun[k], ovr);
      checkOutput($sformatf("%s_iready%0d", tag, k), iReady[k], 1'b1);
    end
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    oReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: oReady = 1'b1;
        1: oReady = $urandom_range(0, 1) != 0;
        2: begin
          if (oValid[0]) begin
            oReady = pat[pIdx % 7] != 0;
            pIdx++;
          end else begin
            oReady = 1'b1;
          end
        end
        default: oReady = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and watches stalls.
  always @(negedge clk) begin
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("done%0d", k), oDone[k], doneDue[k]);
      checkOutput($sformatf("iReady%0d", k), iReady[k], !oValid[k]);
      if (prevStall[k]) begin
        checkOutput($sformatf("stallValid%0d", k), oValid[k], 1'b1);
        checkOutput($sformatf("stallData%0d", k), oData[k], prevData[k]);
        checkOutput($sformatf("stallLast%0d", k), oLast[k], prevLast[k]);
      end
      if (!oValid[k]) begin
        checkOutput($sformatf("idleData%0d", k), oData[k], '0);
        checkOutput($sformatf("idleLast%0d", k), oLast[k], 1'b0);
      end else if (oReady) begin
        if ((k == 0 ? expQ0.size() : expQ1.size()) == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL beat%0d: got unexpected %h expected none", k, oData[k]);
        end else begin
          b = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
          checkOutput($sformatf("beatData%0d", k), oData[k], b.data);
          checkOutput($sformatf("beatLast%0d", k), oLast[k], b.last);
        end
      end
      doneDue[k]   = oValid[k] && oReady && oLast[k] && rst && !clr;
      prevStall[k] = oValid[k] && !oReady && rst && !clr;
      prevData[k]  = oData[k];
      prevLast[k]  = oLast[k];
    end
  end

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    iValid = 1'b0;
    ofData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset", 1'b0);
    rst = 1'b1;

    $display("[TB] basic tile");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) vals[r][c] = 16 * r + c;
    readyMode = 0;
    applyStimulus(0, -1);
    waitDrained();

    $display("[TB] backpressure");
    pIdx = 0;
    readyMode = 2;
    applyStimulus(0, -1);
    waitDrained();

    $display("[TB] input gap");
    readyMode = 0;
    applyStimulus(1, -1);
    waitDrained();
    checkIdleOutputs("afterGap", 1'b0);

    $display("[TB] random tiles");
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) vals[r][c] = $urandom;
      readyMode = 1;
      applyStimulus(2, -1);
      waitDrained();
    end

    $display("[TB] relu values");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) vals[r][c] = $urandom_range(0, 1000);
    vals[0][0] = 32'hFFFF_FFFB;
    vals[1][2] = 32'h0000_0007;
    vals[3][3] = 32'hFFFF_FFFB;
    readyMode = 0;
    applyStimulus(0, -1);
    waitDrained();

    $display("[TB] overrun");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) vals[r][c] = $urandom;
    readyMode = 3;
    applyStimulus(0, -1);
    iValid = 1'b1;
    ofData = {COLS{32'hDEAD_BEEF}};
    @(posedge clk);
    #1;
    iValid = 1'b0;
    for (int k = 0; k < 2; k++) checkOutput($sformatf("overrunSet%0d", k), oOverrun[k], 1'b1);
    readyMode = 0;
    waitDrained();
    for (int k = 0; k < 2; k++) checkOutput($sformatf("overrunSticky%0d", k), oOverrun[k], 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkIdleOutputs("afterClr", 1'b0);

    $display("[TB] reset mid-capture");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) vals[r][c] = $urandom;
    applyStimulus(0, 2);
    checkIdleOutputs("midReset", 1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) vals[r][c] = $urandom;
    applyStimulus(0, -1);
    waitDrained();

    checkOutput("queueEmpty0", expQ0.size(), 0);
    checkOutput("queueEmpty1", expQ1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
